// File: rtl/cic_comp_pkg.sv
// Shared constants for the CIC compensation FIR: coefficient ROM (Q1.14, unity DC gain)
// and the FSM state encoding.
package cic_comp_pkg;

    localparam int TAP_NUM    = 7;
    localparam int COEF_WIDTH = 16;
    localparam int COEF_FRAC  = 14;

    // Symmetric taps; they sum to 16384, i.e. 1.0 in Q1.14.
    localparam logic signed [COEF_WIDTH-1:0] COEF [TAP_NUM] = '{
        -16'sd256, 16'sd1024, -16'sd3072, 16'sd20992, -16'sd3072, 16'sd1024, -16'sd256
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/cic_comp_round_sat.sv
// Round-half-up arithmetic right shift of the accumulator down to the output width.
// With CIC_COMP_SAT_EN defined the result clamps to the output range; otherwise it wraps.
module cic_comp_round_sat #(
    parameter int AccWidth     = 48,
    parameter int OutShift     = 26,
    parameter int OutDataWidth = 16
) (
    input  logic signed [AccWidth-1:0]     acc_i,
    output logic        [OutDataWidth-1:0] data_o,
    output logic                           sat_o
);

    localparam int RW = AccWidth - OutShift;
    localparam logic [AccWidth-1:0] HALF = AccWidth'(1) << (OutShift - 1);

    logic [AccWidth-1:0] sum;
    logic [RW-1:0]       r;
    logic                unused_bits;

    assign sum = acc_i + HALF;
    assign r   = sum[AccWidth-1:OutShift];

`ifdef CIC_COMP_SAT_EN
    logic in_range;

    // r fits when every bit above the output sign bit agrees with it.
    assign in_range = (&r[RW-1:OutDataWidth-1]) || (~|r[RW-1:OutDataWidth-1]);

    always_comb begin
        sat_o  = 1'b0;
        data_o = r[OutDataWidth-1:0];
        if (!in_range) begin
            sat_o  = 1'b1;
            data_o = r[RW-1] ? {1'b1, {(OutDataWidth-1){1'b0}}}
                             : {1'b0, {(OutDataWidth-1){1'b1}}};
        end
    end

    assign unused_bits = ^sum[OutShift-1:0];
`else
    assign data_o      = r[OutDataWidth-1:0];
    assign sat_o       = 1'b0;
    assign unused_bits = ^{sum[OutShift-1:0], r[RW-1:OutDataWidth]};
`endif

endmodule

// File: rtl/cic_comp_fir.sv
// Time-multiplexed CIC droop compensation FIR: one MAC, one tap per clock, circular sample
// buffer, 28b -> 16b with rounding. Optional output clamping via CIC_COMP_SAT_EN.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int InDataWidth  = 28,
    parameter int OutDataWidth = 16,
    parameter int AccWidth     = 48,
    parameter int OutShift     = 26
) (
    input  logic                    Clk_i,
    input  logic                    Rst_i,
    input  logic [InDataWidth-1:0]  Data_i,
    input  logic                    DataNd_i,
    output logic [OutDataWidth-1:0] Data_o,
    output logic                    DataValid_o,
    output logic                    Busy_o,
    output logic                    Overrun_o,
    output logic                    Sat_o
);

    localparam int CoefWidth = COEF_WIDTH;
    localparam int TapNum    = TAP_NUM;
    localparam int PTR_W     = $clog2(TapNum);
    localparam int PW        = InDataWidth + CoefWidth;
    localparam logic [PTR_W-1:0] TAP_P    = PTR_W'(TapNum);
    localparam logic [PTR_W-1:0] TAP_LAST = PTR_W'(TapNum - 1);

    state_e                         state_q, state_d;
    logic [PTR_W-1:0]               k_q, k_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
    logic signed [AccWidth-1:0]     acc_q, acc_d;
    logic signed [InDataWidth-1:0]  samp_q [TapNum];
    logic signed [InDataWidth-1:0]  samp_d [TapNum];
    logic [OutDataWidth-1:0]        data_q, data_d;
    logic                           valid_q, valid_d;
    logic                           sat_q, sat_d;
    logic                           overrun_q, overrun_d;

    logic [PTR_W-1:0]               rd_idx;
    logic signed [PW-1:0]           samp_ext, coef_ext, prod;
    logic signed [AccWidth-1:0]     prod_acc;
    logic [OutDataWidth-1:0]        rs_data;
    logic                           rs_sat;

    // Tap k pairs with the sample written k strobes ago: buf[(wr_ptr - k) mod TapNum].
    always_comb begin
        rd_idx   = (wr_ptr_q >= k_q) ? (wr_ptr_q - k_q) : (wr_ptr_q + TAP_P - k_q);
        samp_ext = {{CoefWidth{samp_q[rd_idx][InDataWidth-1]}}, samp_q[rd_idx]};
        coef_ext = {{InDataWidth{COEF[k_q][CoefWidth-1]}}, COEF[k_q]};
        prod     = samp_ext * coef_ext;
        prod_acc = {{(AccWidth-PW){prod[PW-1]}}, prod};
    end

    cic_comp_round_sat #(
        .AccWidth     (AccWidth),
        .OutShift     (OutShift),
        .OutDataWidth (OutDataWidth)
    ) u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wr_ptr_d  = wr_ptr_q;
        acc_d     = acc_q;
        samp_d    = samp_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        sat_d     = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (DataNd_i) begin
                    samp_d[wr_ptr_q] = Data_i;
                    k_d              = '0;
                    acc_d            = '0;
                    state_d          = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + prod_acc;
                if (k_q == TAP_LAST) begin
                    wr_ptr_d = (wr_ptr_q == TAP_LAST) ? '0 : wr_ptr_q + 1'b1;
                    state_d  = ST_ROUND;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_ROUND: begin
                data_d  = rs_data;
                sat_d   = rs_sat;
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A strobe outside IDLE is dropped; remember that it happened.
        if (DataNd_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            wr_ptr_q  <= '0;
            acc_q     <= '0;
            samp_q    <= '{default: '0};
            data_q    <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wr_ptr_q  <= wr_ptr_d;
            acc_q     <= acc_d;
            samp_q    <= samp_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
            overrun_q <= overrun_d;
        end
    end

    assign Data_o      = data_q;
    assign DataValid_o = valid_q;
    assign Busy_o      = (state_q != ST_IDLE);
    assign Overrun_o   = overrun_q;
    assign Sat_o       = sat_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed/randomized bench for cic_comp_fir against a sum-of-products reference model.
// Follows CIC_COMP_SAT_EN for the expected clamp/wrap behaviour.
module tb_cic_comp_fir;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [27:0] data_i;
    logic        nd;
    logic [15:0] data_o;
    logic        valid;
    logic        busy;
    logic        overrun;
    logic        sat;

    int n_cmp = 0;
    int n_mis = 0;

    longint      hist[$];
    longint      coef_m [7] = '{-256, 1024, -3072, 20992, -3072, 1024, -256};
    logic [15:0] last_d;

    always #5 clk = ~clk;

    cic_comp_fir dut (
        .Clk_i       (clk),
        .Rst_i       (rst_n),
        .Data_i      (data_i),
        .DataNd_i    (nd),
        .Data_o      (data_o),
        .DataValid_o (valid),
        .Busy_o      (busy),
        .Overrun_o   (overrun),
        .Sat_o       (sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 7; i++) hist.push_back(0);
    endfunction

    // y = sum coef[k]*x[n-k]; round half up by 2^26; then clamp or wrap to 16 bits.
    task automatic model_accept(input longint x, output logic [15:0] exp_d,
                                output logic exp_s);
        longint y;
        longint r;
        hist.push_front(x);
        void'(hist.pop_back());
        y = 0;
        for (int k = 0; k < 7; k++) y += coef_m[k] * hist[k];
        r = (y + (longint'(1) <<< 25)) >>> 26;
        exp_s = 1'b0;
        exp_d = 16'(r);
`ifdef CIC_COMP_SAT_EN
        if (r > 32767) begin
            exp_d = 16'h7fff;
            exp_s = 1'b1;
        end else if (r < -32768) begin
            exp_d = 16'h8000;
            exp_s = 1'b1;
        end
`endif
    endtask

    // One strobe, then 11 more clocks (spacing 12). Optionally inject a second strobe at tick inj_at.
    task automatic run_sample(input string tag, input logic [27:0] x, input int inj_at,
                              input logic [27:0] inj_val);
        logic [15:0] exp_d;
        logic        exp_s;
        logic [15:0] got_d;
        logic        got_s;
        int          first_v;
        int          pulses;
        int          busy_bad;
        model_accept(longint'($signed(x)), exp_d, exp_s);
        got_d    = '0;
        got_s    = 1'b0;
        first_v  = 0;
        pulses   = 0;
        busy_bad = 0;
        data_i   = x;
        nd       = 1'b1;
        tick();
        nd       = 1'b0;
        data_i   = 28'($urandom);
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) begin
                if (n == inj_at) begin
                    nd     = 1'b1;
                    data_i = inj_val;
                end
                tick();
                nd = 1'b0;
            end
            if (valid === 1'b1) begin
                pulses++;
                if (first_v == 0) begin
                    first_v = n;
                    got_d   = data_o;
                    got_s   = sat;
                end
            end
            if (busy !== (n <= 9)) busy_bad++;
        end
        last_d = got_d;
        check({tag, ".pulses"},  pulses, 1);
        check({tag, ".latency"}, first_v, 9);
        check({tag, ".data"},    32'($signed(got_d)), 32'($signed(exp_d)));
        check({tag, ".sat"},     32'(got_s), 32'(exp_s));
        check({tag, ".busy"},    busy_bad, 0);
    endtask

    task automatic run_impulse(input string tag, input logic [27:0] amp);
        run_sample($sformatf("%s[0]", tag), amp, 0, '0);
        for (int i = 1; i < 8; i++) run_sample($sformatf("%s[%0d]", tag, i), '0, 0, '0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".data"},    32'($signed(data_o)), 0);
        check({tag, ".valid"},   32'(valid), 0);
        check({tag, ".busy"},    32'(busy), 0);
        check({tag, ".overrun"}, 32'(overrun), 0);
        check({tag, ".sat"},     32'(sat), 0);
    endtask

    initial begin
        int pulses;
        rst_n  = 1'b0;
        nd     = 1'b0;
        data_i = '0;
        last_d = '0;
        model_reset();

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Impulse response
        run_impulse("impulse", 28'd67108864);
        check("impulse.overrun", 32'(overrun), 0);

        // DC gain
        for (int i = 0; i < 10; i++) run_sample($sformatf("dc[%0d]", i), 28'd16777216, 0, '0);
        check("dc.settled", 32'($signed(last_d)), 4096);

        // Random samples over the full input range
        for (int i = 0; i < 16; i++) run_sample($sformatf("rand[%0d]", i), 28'($urandom), 0, '0);

        // Positive full scale
        for (int i = 0; i < 8; i++) run_sample($sformatf("sat_pos[%0d]", i), 28'h7ffffff, 0, '0);
`ifdef CIC_COMP_SAT_EN
        check("sat_pos.settled", 32'($signed(last_d)), 32767);
`else
        check("sat_pos.settled", 32'($signed(last_d)), -32768);
`endif

        // Negative full scale
        for (int i = 0; i < 8; i++) run_sample($sformatf("sat_neg[%0d]", i), 28'h8000000, 0, '0);

        // Flush, then small negative impulse
        for (int i = 0; i < 7; i++) run_sample($sformatf("flush[%0d]", i), '0, 0, '0);
        run_impulse("neg_imp", 28'(-(32'sd33554432)));

        // Overrun: second strobe 3 clocks after the first is dropped
        run_sample("ovr[0]", 28'd67108864, 4, 28'($urandom_range(1, 1000000)));
        check("ovr.set", 32'(overrun), 1);
        for (int i = 1; i < 8; i++) run_sample($sformatf("ovr[%0d]", i), '0, 0, '0);
        check("ovr.sticky", 32'(overrun), 1);

        // Leave non-zero history behind before the mid-MAC reset
        for (int i = 0; i < 3; i++) run_sample($sformatf("pre_rst[%0d]", i), 28'($urandom), 0, '0);

        // Reset at tap k=3 of a MAC sequence
        data_i = 28'($urandom_range(1, 100000000));
        nd     = 1'b1;
        tick();
        nd = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        tick();
        rst_n = 1'b1;
        model_reset();
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (valid === 1'b1) pulses++;
        end
        check("mid_rst.no_valid", pulses, 0);
        run_impulse("post_rst", 28'd67108864);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
